// File: rtl/seg7_parity_tx.sv
// Serial transmitter for the 5-bit parity-protected 7-segment digit link.
// Define SEG7_PARITY_INJECT_EN to add the inject_err input, which sends the wrong parity bit.
module seg7_parity_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_CODE     = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] tx_data,
`ifdef SEG7_PARITY_INJECT_EN
    input  logic       inject_err,
`endif
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       busy,
    output logic       done,
    output logic       range_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] MAX_C    = 5'(MAX_CODE);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] idx, idx_nxt;
    logic [4:0] shreg, shreg_nxt;
    logic       par, par_nxt;
    logic       line_nxt, done_nxt, rerr_nxt;
    logic       bit_end;
    logic       parity_calc;

`ifdef SEG7_PARITY_INJECT_EN
    assign parity_calc = (^tx_data) ^ inject_err;
`else
    assign parity_calc = ^tx_data;
`endif

    // Outputs are derived from the next state so that every output is a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par;
        done_nxt  = 1'b0;
        rerr_nxt  = 1'b0;
        line_nxt  = 1'b1;
        bit_end   = (cnt == LAST_CNT);

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    if (tx_data <= MAX_C) begin
                        shreg_nxt = tx_data;
                        par_nxt   = parity_calc;
                        cnt_nxt   = 8'd0;
                        idx_nxt   = 3'd0;
                        state_nxt = START;
                    end else begin
                        rerr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                cnt_nxt = bit_end ? 8'd0 : cnt + 8'd1;
                if (bit_end) begin
                    case (state)
                        START: state_nxt = DATA;
                        DATA: begin
                            if (idx == 3'd4) begin
                                state_nxt = PARITY;
                            end else begin
                                idx_nxt   = idx + 3'd1;
                                shreg_nxt = {shreg[3:0], 1'b0};
                            end
                        end
                        PARITY: state_nxt = STOP;
                        STOP: begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        endcase

        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shreg_nxt[4];
            PARITY:  line_nxt = par_nxt;
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= 3'd0;
            shreg     <= 5'd0;
            par       <= 1'b0;
            tx_line   <= 1'b1;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            par       <= par_nxt;
            tx_line   <= line_nxt;
            tx_ready  <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
            range_err <= rerr_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_parity_tx.sv
// Self-checking bench for seg7_parity_tx with CLKS_PER_BIT=4: table of codes, scoreboarded frames,
// plus back-to-back, mid-frame toggling, reset abort and (with SEG7_PARITY_INJECT_EN) parity injection.
module tb_seg7_parity_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] tx_data = 5'd0;
    logic       tx_valid = 1'b0;
`ifdef SEG7_PARITY_INJECT_EN
    logic       inject_err = 1'b0;
`endif
    logic       tx_ready, tx_line, busy, done, range_err;

    seg7_parity_tx #(.CLKS_PER_BIT(CPB), .MAX_CODE(19)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
`ifdef SEG7_PARITY_INJECT_EN
        .inject_err(inject_err),
`endif
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_line   (tx_line),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic       reject;
        logic [7:0] frame;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] sb[$];
    int tests = 0, fails = 0;
    int frames_seen = 0, frames_pushed = 0, rejects_driven = 0;
    int done_count = 0, rerr_count = 0, overlap_count = 0;
    logic mon_en = 1'b1;
    logic prev_busy = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each frame bit is held for CPB cycles, start bit first.
    function automatic logic [31:0] expand(input logic [7:0] f);
        logic [31:0] e;
        for (int i = 0; i < 8 * CPB; i++) e[31 - i] = f[7 - i / CPB];
        return e;
    endfunction

    // Called at a negedge; offers one code and checks the immediate reaction.
    task automatic applyStimulus(input logic [4:0] code, input logic reject,
                                 input logic [7:0] frame, input logic push);
        int c = 0;
        while (!tx_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput("ready_wait", tx_ready, 1);
        tx_data  = code;
        tx_valid = 1'b1;
        if (!reject && push) begin
            sb.push_back(frame);
            frames_pushed++;
        end
        if (reject) rejects_driven++;
        @(negedge clk);
        tx_valid = 1'b0;
        if (reject) begin
            checkOutput("rerr_pulse", {range_err, tx_line, tx_ready, busy}, 4'b1110);
            @(negedge clk);
            checkOutput("rerr_clear", {range_err, tx_line, tx_ready, busy}, 4'b0110);
        end else begin
            checkOutput("accept_start", {tx_line, busy, tx_ready}, 3'b010);
        end
    endtask

    task automatic waitFrames(input int target);
        int c = 0;
        while (frames_seen < target && c < 400) begin
            @(negedge clk);
            c++;
        end
        checkOutput("frame_wait", frames_seen, target);
    endtask

    // Frame monitor: captures every cycle of a frame and pops the scoreboard at its done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && busy && !prev_busy) begin
                logic [31:0] cap;
                logic [7:0]  expf;
                cap[31] = tx_line;
                for (int i = 1; i < 8 * CPB; i++) begin
                    @(negedge clk);
                    cap[31 - i] = tx_line;
                end
                @(negedge clk);
                checkOutput("done_cycle", {done, busy, tx_ready, tx_line}, 4'b1011);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_frame: got %0h, expected no frame", cap);
                end else begin
                    expf = sb.pop_front();
                    checkOutput("frame_bits", cap, expand(expf));
                end
                frames_seen++;
            end
            prev_busy = busy;
        end
    end

    always @(negedge clk) begin
        if (done) done_count <= done_count + 1;
        if (range_err) rerr_count <= rerr_count + 1;
        if (done && range_err) overlap_count <= overlap_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{code: 5'd19, reject: 1'b0, frame: 8'b01001111};
        vecs[1] = '{code: 5'd20, reject: 1'b1, frame: 8'b11111111};
        vecs[2] = '{code: 5'd31, reject: 1'b1, frame: 8'b11111111};
        vecs[3] = '{code: 5'd3,  reject: 1'b0, frame: 8'b00001101};
        vecs[4] = '{code: 5'd10, reject: 1'b0, frame: 8'b00101001};
        vecs[5] = '{code: 5'd0,  reject: 1'b0, frame: 8'b00000001};
        vecs[6] = '{code: 5'd7,  reject: 1'b0, frame: 8'b00011111};

        repeat (3) @(negedge clk);
        checkOutput("reset_state", {tx_line, tx_ready, busy, done, range_err}, 5'b10000);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", {tx_line, tx_ready, busy}, 3'b110);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].code, vecs[i].reject, vecs[i].frame, 1'b1);
            if (!vecs[i].reject) waitFrames(frames_pushed);
        end

        // Back-to-back: second code offered during the done cycle.
        applyStimulus(5'd5, 1'b0, 8'b00010101, 1'b1);
        begin
            int c = 0;
            while (!done && c < 100) begin
                @(negedge clk);
                c++;
            end
        end
        checkOutput("b2b_done_seen", done, 1);
        tx_data  = 5'd0;
        tx_valid = 1'b1;
        sb.push_back(8'b00000001);
        frames_pushed++;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("b2b_start", {tx_line, busy}, 2'b01);
        waitFrames(frames_pushed);

        // Inputs wiggle mid-frame; the latched code must go out unchanged.
        applyStimulus(5'd10, 1'b0, 8'b00101001, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        tx_valid = 1'b0;
        waitFrames(frames_pushed);
        repeat (5) @(negedge clk);
        checkOutput("no_extra_frame", busy, 0);

        // Reset during the DATA phase aborts the frame.
        mon_en = 1'b0;
        applyStimulus(5'd12, 1'b0, 8'b00110001, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_abort", {tx_line, busy, done, tx_ready}, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold", {tx_line, busy, done}, 3'b100);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_abort", {tx_line, tx_ready, busy}, 3'b110);
        mon_en = 1'b1;
        applyStimulus(5'd3, 1'b0, 8'b00001101, 1'b1);
        waitFrames(frames_pushed);

`ifdef SEG7_PARITY_INJECT_EN
        inject_err = 1'b1;
        applyStimulus(5'd7, 1'b0, 8'b00011101, 1'b1);
        repeat (5) @(negedge clk);
        inject_err = 1'b0;
        waitFrames(frames_pushed);
        applyStimulus(5'd7, 1'b0, 8'b00011111, 1'b1);
        repeat (5) @(negedge clk);
        inject_err = 1'b1;
        repeat (5) @(negedge clk);
        inject_err = 1'b0;
        waitFrames(frames_pushed);
`endif

        repeat (5) @(negedge clk);
        checkOutput("done_total", done_count, frames_pushed);
        checkOutput("rerr_total", rerr_count, rejects_driven);
        checkOutput("done_rerr_overlap", overlap_count, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
